// File: rtl/hash_arb_pkg.sv
// Shared types and core-interface widths for the hash core arbiter.
package hash_arb_pkg;
  localparam int MSG_W = 8;
  localparam int CNT_W = 64;
  localparam int DIG_W = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FEED     = 3'd1,
    S_ISSUE    = 3'd2,
    S_GAP      = 3'd3,
    S_WAIT_DIG = 3'd4,
    S_DONE     = 3'd5
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/hash_core_arbiter.sv
// Shares one hash core between NUM_REQ requesters, one whole message per grant.
// Optional WAIT_DIG watchdog: define HASH_ARB_TIMEOUT_EN.
module hash_core_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LEN_W       = 16,
  parameter int BYTE_GAP    = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]                req_ack,
  input  logic [NUM_REQ-1:0]                in_valid,
  input  logic [NUM_REQ-1:0][MSG_W-1:0]     in_data,
  output logic [NUM_REQ-1:0]                in_ready,
  output logic                              core_m_valid,
  output logic [MSG_W-1:0]                  core_message,
  output logic [CNT_W-1:0]                  core_counter,
  input  logic                              core_hash_ready,
  input  logic [DIG_W-1:0]                  core_digest,
  output logic                              dig_valid,
  output logic [NUM_REQ-1:0]                dig_owner,
  output logic [DIG_W-1:0]                  dig_data,
  output logic                              dig_err
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(BYTE_GAP + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr, owner, gnt_idx;
  logic [NUM_REQ-1:0] gnt, owner_oh;
  logic               gnt_any, to_hit;
  logic [LEN_W-1:0]   len_q, remaining;
  logic [MSG_W-1:0]   byte_q;
  logic [DIG_W-1:0]   dig_q;
  logic               err_q;
  logic [GAP_W-1:0]   gap_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign owner_oh     = NUM_REQ'(1) << owner;
  // Grant is combinational in IDLE; masked while reset is held so outputs read 0.
  assign req_ack      = (state == S_IDLE && rst_n) ? gnt : '0;
  assign in_ready     = (state == S_FEED) ? owner_oh : '0;
  assign core_m_valid = (state == S_ISSUE);
  assign core_message = (state == S_ISSUE) ? byte_q : '0;
  assign core_counter = CNT_W'(len_q);
  assign dig_valid    = (state == S_DONE);
  assign dig_owner    = dig_valid ? owner_oh : '0;
  assign dig_data     = dig_valid ? dig_q : '0;
  assign dig_err      = dig_valid & err_q;

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   to_cnt <= '0;
    else if (state != S_WAIT_DIG) to_cnt <= '0;
    else                          to_cnt <= to_cnt + TO_W'(1);
  end
  assign to_hit = (state == S_WAIT_DIG) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      len_q     <= '0;
      remaining <= '0;
      byte_q    <= '0;
      dig_q     <= '0;
      err_q     <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (gnt_any) begin
          owner     <= gnt_idx;
          ptr       <= gnt_idx;
          len_q     <= req_len[gnt_idx];
          remaining <= req_len[gnt_idx];
          dig_q     <= '0;
          // Zero-length messages never touch the core.
          if (req_len[gnt_idx] == '0) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            err_q <= 1'b0;
            state <= S_FEED;
          end
        end
        S_FEED: if (in_valid[owner]) begin
          byte_q <= in_data[owner];
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (remaining != '0) remaining <= remaining - LEN_W'(1);
          gap_cnt <= '0;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(BYTE_GAP - 1))
            state <= (remaining != '0) ? S_FEED : S_WAIT_DIG;
          else
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
        S_WAIT_DIG: begin
          if (core_hash_ready) begin
            dig_q <= core_digest;
            err_q <= 1'b0;
            state <= S_DONE;
          end else if (to_hit) begin
            dig_q <= '0;
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_core_arbiter.sv
// Randomized bench: per-requester drivers + core model; a separate monitor scores against a round-robin reference.
module tb_hash_core_arbiter;
  localparam int N = 4, LW = 16, GAP = 3, TO = 64, MAXL = 8;
  localparam logic [31:0] FNV0 = 32'h811C_9DC5;
  localparam int R_IDLE = 0, R_REQ = 1, R_FEED = 2, R_WAIT = 3;

  logic clk = 1'b0, rst_n;
  logic [N-1:0] req_valid, req_ack, in_valid, in_ready, dig_owner;
  logic [N-1:0][LW-1:0] req_len;
  logic [N-1:0][7:0] in_data;
  logic core_m_valid, core_hash_ready, dig_valid, dig_err;
  logic [7:0] core_message;
  logic [63:0] core_counter;
  logic [31:0] core_digest, dig_data;

  always #5 clk = ~clk;

  hash_core_arbiter #(.NUM_REQ(N), .LEN_W(LW), .BYTE_GAP(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len), .req_ack(req_ack),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_m_valid(core_m_valid), .core_message(core_message), .core_counter(core_counter),
    .core_hash_ready(core_hash_ready), .core_digest(core_digest),
    .dig_valid(dig_valid), .dig_owner(dig_owner), .dig_data(dig_data), .dig_err(dig_err)
  );

  typedef struct { int owner; logic [31:0] data; bit err; bit to; int ack_cyc; } exp_t;

  int checks = 0, fails = 0, cyc = 0;
  logic [7:0] mbuf [N][MAXL];
  int blen [N], st [N], idx [N], left [N];
  bit auto_en = 0, no_stall = 0, core_mute = 0;
  int hold = 0, issue_cnt = 0;
  int rx_cnt = 0, pwait = 0;
  bit pend = 0;
  logic [31:0] rx_h, pdig;

  exp_t exp_d [$];
  logic [7:0] exp_b [$];
  int exp_len = 0, last_rr = N - 1, last_issue = 0, mon_w;
  bit first_b = 0;
  logic [31:0] mon_h;
  exp_t mon_e;

  function automatic logic [31:0] fnv(logic [31:0] h, logic [7:0] b);
    return (h ^ {24'd0, b}) * 32'h0100_0193;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: round-robin winner from the request vector, expected bytes and digests.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      exp_d.delete(); exp_b.delete(); last_rr = N - 1;
      chk("rst_outs", 64'({req_ack, in_ready, dig_owner, core_m_valid, core_message, dig_valid, dig_err}), 0);
      chk("rst_counter", core_counter, 0);
      chk("rst_dig_data", 64'(dig_data), 0);
    end else begin
      if (req_ack != '0) begin
        mon_w = -1;
        for (int k = 1; k <= N; k++)
          if (mon_w < 0 && req_valid[(last_rr + k) % N]) mon_w = (last_rr + k) % N;
        if (mon_w < 0) chk("ack_spurious", 64'(req_ack), 0);
        else begin
          chk("ack_rr", 64'(req_ack), 64'(1) << mon_w);
          last_rr = mon_w; exp_len = blen[mon_w]; first_b = 1; mon_h = FNV0;
          for (int b = 0; b < blen[mon_w]; b++) begin
            exp_b.push_back(mbuf[mon_w][b]);
            mon_h = fnv(mon_h, mbuf[mon_w][b]);
          end
          mon_e.owner = mon_w; mon_e.data = mon_h; mon_e.err = (blen[mon_w] == 0);
          mon_e.to = 0; mon_e.ack_cyc = cyc;
`ifdef HASH_ARB_TIMEOUT_EN
          if (core_mute && blen[mon_w] != 0) begin mon_e.err = 1; mon_e.data = 0; mon_e.to = 1; end
`endif
          exp_d.push_back(mon_e);
        end
      end
      if (core_m_valid) begin
        if (exp_b.size() == 0) chk("byte_unexpected", 64'(core_m_valid), 0);
        else chk("byte", 64'(core_message), 64'(exp_b.pop_front()));
        chk("counter", core_counter, 64'(exp_len));
        if (no_stall && !first_b) chk("byte_pace", 64'(cyc - last_issue), GAP + 2);
        first_b = 0; last_issue = cyc;
      end
      if (in_ready != '0) chk("in_ready_owner", 64'(in_ready), 64'(1) << last_rr);
      if (dig_valid) begin
        if (exp_d.size() == 0) chk("dig_unexpected", 64'(dig_valid), 0);
        else begin
          mon_e = exp_d.pop_front();
          chk("dig_owner", 64'(dig_owner), 64'(1) << mon_e.owner);
          chk("dig_err", 64'(dig_err), 64'(mon_e.err));
          if (!(mon_e.err && !mon_e.to)) chk("dig_data", 64'(dig_data), 64'(mon_e.data));
          if (mon_e.err && !mon_e.to) chk("zero_len_lat", 64'(cyc - mon_e.ack_cyc), 1);
          if (mon_e.to) chk("timeout_lat", 64'(cyc - last_issue), GAP + 1 + TO);
        end
      end
    end
  end

  task automatic start_req(int i, int len);
    blen[i] = len;
    for (int b = 0; b < MAXL; b++) mbuf[i][b] = 8'($urandom);
    req_valid[i] = 1'b1; req_len[i] = LW'(len); st[i] = R_REQ;
    if (left[i] > 0) left[i]--;
  endtask

  // One clock: sample at negedge, then drive requesters and the core model after posedge.
  task automatic cyc_step();
    logic [N-1:0] ack, rdy, dv, own;
    @(negedge clk);
    ack = req_ack; rdy = in_ready; dv = dig_valid; own = dig_owner;
    if (core_m_valid) begin
      issue_cnt++; rx_cnt++; rx_h = fnv(rx_h, core_message);
      if (64'(rx_cnt) == core_counter) begin
        pdig = rx_h; rx_cnt = 0; rx_h = FNV0;
        if (!core_mute) begin pend = 1; pwait = GAP + $urandom_range(0, 4); end
      end
    end
    @(posedge clk); #1;
    core_hash_ready = 1'b0;
    if (pend) begin
      if (pwait == 0) begin core_hash_ready = 1'b1; core_digest = pdig; pend = 0; end
      else pwait--;
    end else if (rx_cnt > 0 && $urandom_range(0, 5) == 0) begin
      core_hash_ready = 1'b1; core_digest = $urandom;
    end
    if (hold > 0) hold--;
    for (int i = 0; i < N; i++) begin
      case (st[i])
        R_IDLE: if (auto_en && left[i] > 0 && $urandom_range(0, 3) == 0)
                  start_req(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAXL));
        R_REQ:  if (ack[i]) begin
                  req_valid[i] = 1'b0; idx[i] = 0;
                  st[i] = (blen[i] == 0) ? R_WAIT : R_FEED;
                end
        R_FEED: if (rdy[i] && in_valid[i]) begin
                  idx[i]++;
                  if (idx[i] == blen[i]) st[i] = R_WAIT;
                end
        default: if (dv && own[i]) st[i] = R_IDLE;
      endcase
      if (st[i] == R_FEED) begin
        in_valid[i] = (hold == 0) && (no_stall || $urandom_range(0, 2) != 0);
        in_data[i]  = mbuf[i][idx[i]];
      end else begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_data[i]  = 8'($urandom);
      end
    end
  endtask

  function automatic bit all_idle();
    bit r = !pend;
    for (int i = 0; i < N; i++) if (st[i] != R_IDLE || (auto_en && left[i] > 0)) r = 0;
    return r;
  endfunction

  task automatic run_idle(int bound);
    int n = 0;
    do begin cyc_step(); n++; end while (!all_idle() && n < bound);
    chk("phase_done", 64'(all_idle()), 1);
  endtask

  task automatic wait_issue(int target, int bound);
    int n = 0;
    while (issue_cnt < target && n < bound) begin cyc_step(); n++; end
    chk("issue_seen", 64'(issue_cnt >= target), 1);
  endtask

  task automatic clear_bench();
    req_valid = '0; req_len = '0; in_valid = '0; in_data = '0;
    core_hash_ready = 1'b0; core_digest = '0;
    pend = 0; rx_cnt = 0; rx_h = FNV0; hold = 0;
    for (int i = 0; i < N; i++) begin st[i] = R_IDLE; left[i] = 0; idx[i] = 0; blen[i] = 0; end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    clear_bench();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single message, back-to-back bytes.
    no_stall = 1;
    start_req(0, 3);
    mbuf[0][0] = 8'h61; mbuf[0][1] = 8'h62; mbuf[0][2] = 8'h63;
    run_idle(200);

    // Concurrent requests, then a partial re-request.
    for (int i = 0; i < N; i++) start_req(i, 1);
    run_idle(300);
    start_req(0, 1); start_req(2, 1); start_req(3, 1);
    run_idle(300);

    // Owner stalls mid-message while others wiggle in_valid.
    no_stall = 0;
    base = issue_cnt;
    start_req(0, 4);
    wait_issue(base + 1, 100);
    hold = 10;
    run_idle(300);

    // Zero-length request.
    start_req(2, 0);
    run_idle(50);

    // Random traffic.
    auto_en = 1;
    for (int i = 0; i < N; i++) left[i] = 8;
    run_idle(20000);
    auto_en = 0;

    // Reset during the gap after byte 2 of 4.
    no_stall = 1;
    base = issue_cnt;
    start_req(0, 4);
    wait_issue(base + 2, 100);
    #1 rst_n = 1'b0;
    clear_bench();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < N; i++) start_req(i, 1);
    run_idle(300);

    // Core never answers.
    core_mute = 1;
    start_req(1, 2);
`ifdef HASH_ARB_TIMEOUT_EN
    run_idle(400);
    core_mute = 0;
`else
    repeat (1000) cyc_step();
    chk("wait_dig_holds", 64'(st[1] == R_WAIT), 1);
    core_mute = 0;
    pend = 1; pwait = 0;
    run_idle(50);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/hash_core_arbiter.md
Name: hash_core_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one full_hash_des_box core between NUM_REQ requesters.
- Grants the core to one requester for an entire message.
- Streams that requester's bytes into the core at the core's byte pace, then returns the 32-bit digest to the owner.
- Sits between the requester-side byte sources and the single hash core instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 16, width of requested message length in bytes.
- BYTE_GAP, 3, cycles after each core_m_valid pulse before the next byte may be issued (core S1/S2/S0 turnaround).
- TIMEOUT_CYC, 64, WAIT_DIG watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request, held until req_ack
- req_len  in  NUM_REQ*LEN_W  per-requester message length, slice i valid with req_valid[i]
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse on grant
- in_valid  in  NUM_REQ  per-requester byte valid
- in_data  in  NUM_REQ*8  per-requester byte
- in_ready  out  NUM_REQ  one-hot; only the owner may be ready
- core_m_valid  out  1  to core M_valid
- core_message  out  8  to core message
- core_counter  out  64  to core counter; zero-extended latched length
- core_hash_ready  in  1  from core hash_ready
- core_digest  in  32  from core digest_out
- dig_valid  out  1  1-cycle digest strobe
- dig_owner  out  NUM_REQ  one-hot owner of dig_valid
- dig_data  out  32  digest
- dig_err  out  1  with dig_valid: aborted or zero-length

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, FEED, ISSUE, GAP, WAIT_DIG, DONE.
- IDLE:
  - Search req_valid from pointer+1 with wrap-around; the first hit is the owner.
  - Same cycle: pulse req_ack[owner], latch owner, len and remaining=len, update pointer=owner.
  - If len==0, go to DONE with err=1 and no core activity. Otherwise go to FEED.
  - No request: stay IDLE.
- FEED:
  - in_ready[owner]=1.
  - On in_valid[owner]: latch byte, go to ISSUE.
  - Non-owner in_ready stays 0; their in_valid is ignored.
- ISSUE:
  - core_m_valid=1 for exactly one cycle with core_message=byte.
  - core_counter holds the latched length for the whole message.
  - remaining decrements by 1; go to GAP.
- GAP:
  - Count BYTE_GAP cycles.
  - Then: remaining!=0 goes to FEED; remaining==0 goes to WAIT_DIG.
- WAIT_DIG:
  - On core_hash_ready=1: capture core_digest, go to DONE with err=0.
  - A core_hash_ready seen in any other state is ignored.
- DONE:
  - One cycle of dig_valid=1, dig_owner=one-hot(owner), dig_data, dig_err.
  - Then go to IDLE.
  - Earliest next grant is the cycle after DONE.
- Fairness: after serving owner k, requester k has lowest priority. A requester that holds req_valid is granted within NUM_REQ messages.
- Concurrent requests: all requests in the same cycle are resolved by round-robin. req_valid changes during an active message are only evaluated in IDLE.
- Throughput: one byte per BYTE_GAP+2 cycles when the owner supplies bytes back-to-back.
- Reset mid-message: abort immediately to IDLE, outputs 0, no digest emitted. The core is reset by the same rst_n.
- Width rule: remaining is LEN_W bits and never underflows; the decrement happens only in ISSUE, and only when remaining>=1.

Optional Feature:
- Macro HASH_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DIG.
  - After TIMEOUT_CYC cycles without core_hash_ready, go to DONE with dig_err=1, dig_data=0.
  - The counter clears on entry to WAIT_DIG.
- Undefined: WAIT_DIG waits indefinitely. TIMEOUT_CYC is unused and the counter is not synthesised.

Decomposition:
- Package hash_arb_pkg:
  - State enum typedef.
  - Core interface widths: MSG_W=8, CNT_W=64, DIG_W=32.
- Sub-module rr_arbiter (NUM_REQ): combinational grant from request vector and pointer, returns one-hot grant and index.
- The FSM and counters stay in the top module.

Test Plan:
- Single requester 0, len=3, bytes 0x61,0x62,0x63 → three core_m_valid pulses spaced BYTE_GAP+2=5 cycles, core_counter=3 throughout; model core digest 0xDEADBEEF → dig_valid one cycle, dig_owner=0001, dig_data=0xDEADBEEF, dig_err=0.
- All 4 requesters valid simultaneously, len=1 each → grant order 0,1,2,3; then requester 0 re-requests while 2 and 3 also request, served after last=3 → order 0,2,3.
- Owner stalls in_valid 10 cycles mid-message while requester 1 sends in_valid → no core_m_valid during the stall, in_ready[1]=0, and the message completes correctly afterwards.
- Zero-length request from requester 2 (len=0) → req_ack[2], then next cycle dig_valid, dig_owner=0100, dig_err=1, core_m_valid never asserted.
- rst_n low during GAP of byte 2 of 4 → all outputs 0 asynchronously; after release, requester 0 is granted first and no stale dig_valid appears.
- With HASH_ARB_TIMEOUT_EN, TIMEOUT_CYC=64, core never responds → dig_valid with dig_err=1 exactly 64 cycles after WAIT_DIG entry; without the macro, still in WAIT_DIG after 1000 cycles.
